// File: rtl/id_ex_issue.sv
// rtl/id_ex_issue.sv - ID/EX issue register with MEM/WB forwarding, immediate select and load-use bubble insertion
module id_ex_issue #(
    parameter int WIDTH = 32,
    parameter int RADDR = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [WIDTH-1:0] id_rs_data,
    input  logic [WIDTH-1:0] id_rt_data,
    input  logic [WIDTH-1:0] id_imm,
    input  logic [RADDR-1:0] id_rs,
    input  logic [RADDR-1:0] id_rt,
    input  logic [RADDR-1:0] id_rd,
    input  logic [2:0]       id_alu_op,
    input  logic             id_unsig,
    input  logic             id_alusrc,
    input  logic             id_regdst,
    input  logic             id_regwrite,
    input  logic             id_memread,
    input  logic             id_memwrite,
    input  logic             stall,
    input  logic             flush,
    input  logic             mem_regwrite,
    input  logic [RADDR-1:0] mem_rd,
    input  logic [WIDTH-1:0] mem_result,
    input  logic             wb_regwrite,
    input  logic [RADDR-1:0] wb_rd,
    input  logic [WIDTH-1:0] wb_result,
    output logic             ex_valid,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_op,
    output logic             alu_unsig,
    output logic [WIDTH-1:0] ex_rt_data,
    output logic [RADDR-1:0] ex_rd,
    output logic             ex_regwrite,
    output logic             ex_memread,
    output logic             ex_memwrite,
    output logic             load_use_stall
);

    typedef struct packed {
        logic             valid;
        logic [WIDTH-1:0] rs_data;
        logic [WIDTH-1:0] rt_data;
        logic [WIDTH-1:0] imm;
        logic [RADDR-1:0] rs;
        logic [RADDR-1:0] rt;
        logic [RADDR-1:0] rd;
        logic [2:0]       alu_op;
        logic             unsig;
        logic             alusrc;
        logic             regwrite;
        logic             memread;
        logic             memwrite;
    } stage_t;

    stage_t r_q;
    stage_t r_d;
    stage_t id_load;

    logic rs_hit;
    logic rt_hit;

    // Hazard check against the instruction currently in EX; rt only matters when it is read.
    always_comb begin
        rs_hit = (r_q.rd == id_rs);
        rt_hit = (r_q.rd == id_rt) && (!id_alusrc || id_memwrite);
        load_use_stall = id_valid && r_q.valid && r_q.memread &&
                         (r_q.rd != '0) && (rs_hit || rt_hit);
    end

    always_comb begin
        id_load          = '0;
        id_load.valid    = id_valid;
        id_load.rs_data  = id_rs_data;
        id_load.rt_data  = id_rt_data;
        id_load.imm      = id_imm;
        id_load.rs       = id_rs;
        id_load.rt       = id_rt;
        id_load.rd       = id_regdst ? id_rd : id_rt;
        id_load.alu_op   = id_alu_op;
        id_load.unsig    = id_unsig;
        id_load.alusrc   = id_alusrc;
        id_load.regwrite = id_valid && id_regwrite;
        id_load.memread  = id_valid && id_memread;
        id_load.memwrite = id_valid && id_memwrite;
    end

    // flush > stall > load-use bubble > load
    always_comb begin
        r_d = r_q;
        if (flush) begin
            r_d = '0;
        end else if (stall) begin
            r_d = r_q;
        end else if (load_use_stall) begin
            r_d = '0;
        end else begin
            r_d = id_load;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_q <= '0;
        end else begin
            r_q <= r_d;
        end
    end

    logic [WIDTH-1:0] fwd_rs;
    logic [WIDTH-1:0] fwd_rt;

    // Register 0 is hardwired, so a zero index never picks up a forwarded value.
    always_comb begin
        fwd_rs = r_q.rs_data;
        if (r_q.rs != '0) begin
            if (mem_regwrite && (mem_rd == r_q.rs)) begin
                fwd_rs = mem_result;
            end else if (wb_regwrite && (wb_rd == r_q.rs)) begin
                fwd_rs = wb_result;
            end
        end
    end

    always_comb begin
        fwd_rt = r_q.rt_data;
        if (r_q.rt != '0) begin
            if (mem_regwrite && (mem_rd == r_q.rt)) begin
                fwd_rt = mem_result;
            end else if (wb_regwrite && (wb_rd == r_q.rt)) begin
                fwd_rt = wb_result;
            end
        end
    end

    always_comb begin
        ex_valid    = r_q.valid;
        alu_a       = fwd_rs;
        alu_b       = r_q.alusrc ? r_q.imm : fwd_rt;
        alu_op      = r_q.alu_op;
        alu_unsig   = r_q.unsig;
        ex_rt_data  = fwd_rt;
        ex_rd       = r_q.rd;
        ex_regwrite = r_q.regwrite;
        ex_memread  = r_q.memread;
        ex_memwrite = r_q.memwrite;
    end

endmodule

// File: tb/tb_id_ex_issue.sv
// tb/tb_id_ex_issue.sv - table-driven scoreboard bench for id_ex_issue
module tb_id_ex_issue;

    logic        clock;
    logic        reset;
    logic        id_valid;
    logic [31:0] id_rs_data, id_rt_data, id_imm;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic [2:0]  id_alu_op;
    logic        id_unsig, id_alusrc, id_regdst, id_regwrite, id_memread, id_memwrite;
    logic        stall, flush;
    logic        mem_regwrite;
    logic [4:0]  mem_rd;
    logic [31:0] mem_result;
    logic        wb_regwrite;
    logic [4:0]  wb_rd;
    logic [31:0] wb_result;
    logic        ex_valid;
    logic [31:0] alu_a, alu_b, ex_rt_data;
    logic [2:0]  alu_op;
    logic        alu_unsig;
    logic [4:0]  ex_rd;
    logic        ex_regwrite, ex_memread, ex_memwrite, load_use_stall;

    id_ex_issue #(.WIDTH(32), .RADDR(5)) dut (
        .clock(clock), .reset(reset), .id_valid(id_valid),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_alu_op(id_alu_op), .id_unsig(id_unsig), .id_alusrc(id_alusrc),
        .id_regdst(id_regdst), .id_regwrite(id_regwrite), .id_memread(id_memread),
        .id_memwrite(id_memwrite), .stall(stall), .flush(flush),
        .mem_regwrite(mem_regwrite), .mem_rd(mem_rd), .mem_result(mem_result),
        .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_result(wb_result),
        .ex_valid(ex_valid), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_unsig(alu_unsig), .ex_rt_data(ex_rt_data), .ex_rd(ex_rd),
        .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
        .load_use_stall(load_use_stall)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    typedef struct packed {
        logic        valid;
        logic [31:0] rs_data, rt_data, imm;
        logic [4:0]  rs, rt, rd;
        logic [2:0]  op;
        logic        unsig, alusrc, regdst, rw, mr, mw, stall, flush;
        logic        mem_rw;
        logic [4:0]  mem_rd;
        logic [31:0] mem_res;
        logic        wb_rw;
        logic [4:0]  wb_rd;
        logic [31:0] wb_res;
        logic        x_lus, x_valid;
        logic [31:0] x_a, x_b, x_rtd;
        logic [2:0]  x_op;
        logic        x_unsig;
        logic [4:0]  x_rd;
        logic        x_rw, x_mr, x_mw;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];
    vec_t cur;
    vec_t got;
    int   n_checks = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, req);
        end
    endtask

    task automatic add(input logic lus, input logic v, input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] op, input logic u, input logic [31:0] rtd, input logic [4:0] rd,
                       input logic rw, input logic mr, input logic mw);
        cur.x_lus = lus; cur.x_valid = v; cur.x_a = a; cur.x_b = b; cur.x_op = op;
        cur.x_unsig = u; cur.x_rtd = rtd; cur.x_rd = rd; cur.x_rw = rw; cur.x_mr = mr; cur.x_mw = mw;
        tbl.push_back(cur);
        cur = '0;
    endtask

    task automatic apply(input vec_t v);
        id_valid = v.valid; id_rs_data = v.rs_data; id_rt_data = v.rt_data; id_imm = v.imm;
        id_rs = v.rs; id_rt = v.rt; id_rd = v.rd; id_alu_op = v.op; id_unsig = v.unsig;
        id_alusrc = v.alusrc; id_regdst = v.regdst; id_regwrite = v.rw; id_memread = v.mr;
        id_memwrite = v.mw; stall = v.stall; flush = v.flush;
        mem_regwrite = v.mem_rw; mem_rd = v.mem_rd; mem_result = v.mem_res;
        wb_regwrite = v.wb_rw; wb_rd = v.wb_rd; wb_result = v.wb_res;
    endtask

    task automatic chk_outputs(input string tag, input vec_t e);
        chk({tag, ".ex_valid"}, {31'b0, ex_valid}, {31'b0, e.x_valid});
        chk({tag, ".alu_a"}, alu_a, e.x_a);
        chk({tag, ".alu_b"}, alu_b, e.x_b);
        chk({tag, ".alu_op"}, {29'b0, alu_op}, {29'b0, e.x_op});
        chk({tag, ".alu_unsig"}, {31'b0, alu_unsig}, {31'b0, e.x_unsig});
        chk({tag, ".ex_rt_data"}, ex_rt_data, e.x_rtd);
        chk({tag, ".ex_rd"}, {27'b0, ex_rd}, {27'b0, e.x_rd});
        chk({tag, ".ex_regwrite"}, {31'b0, ex_regwrite}, {31'b0, e.x_rw});
        chk({tag, ".ex_memread"}, {31'b0, ex_memread}, {31'b0, e.x_mr});
        chk({tag, ".ex_memwrite"}, {31'b0, ex_memwrite}, {31'b0, e.x_mw});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "timeout");
    end

    initial begin
        cur = '0;
        // v0: plain add, no forwarding
        cur.valid=1; cur.rs=1; cur.rt=2; cur.rd=3; cur.rs_data=5; cur.rt_data=7; cur.op=3'b010; cur.regdst=1; cur.rw=1;
        add(0, 1, 5, 7, 3'b010, 0, 7, 3, 1, 0, 0);
        // v1: immediate on B, rt forwarded from WB into store data
        cur.valid=1; cur.rs=5; cur.rt=6; cur.rd=7; cur.rs_data=32'h100; cur.rt_data=32'h200; cur.imm=32'hFFFF_FFF0;
        cur.alusrc=1; cur.op=3'b110; cur.unsig=1; cur.rw=1; cur.wb_rw=1; cur.wb_rd=6; cur.wb_res=32'h12;
        add(0, 1, 32'h100, 32'hFFFF_FFF0, 3'b110, 1, 32'h12, 6, 1, 0, 0);
        // v2: load to r4
        cur.valid=1; cur.rs=1; cur.rt=4; cur.rd=9; cur.mr=1; cur.rw=1; cur.alusrc=1; cur.imm=8;
        cur.rs_data=32'h1000; cur.rt_data=32'h33; cur.op=3'b010;
        add(0, 1, 32'h1000, 8, 3'b010, 0, 32'h33, 4, 1, 1, 0);
        // v3: consumer of r4 via rs -> bubble
        cur.valid=1; cur.rs=4; cur.rt=2; cur.rd=5; cur.regdst=1; cur.rw=1; cur.rs_data=32'h44; cur.rt_data=32'h55;
        add(1, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0);
        // v4: same consumer reissues after the bubble
        cur.valid=1; cur.rs=4; cur.rt=2; cur.rd=5; cur.regdst=1; cur.rw=1; cur.rs_data=32'h44; cur.rt_data=32'h55;
        add(0, 1, 32'h44, 32'h55, 3'b000, 0, 32'h55, 5, 1, 0, 0);
        // v5: load to r8
        cur.valid=1; cur.rs=2; cur.rt=8; cur.mr=1; cur.rw=1; cur.alusrc=1; cur.imm=4;
        cur.rs_data=32'h10; cur.rt_data=32'h99; cur.op=3'b010;
        add(0, 1, 32'h10, 4, 3'b010, 0, 32'h99, 8, 1, 1, 0);
        // v6: store of r8 (alusrc=1 but memwrite needs rt) -> bubble
        cur.valid=1; cur.rs=3; cur.rt=8; cur.alusrc=1; cur.mw=1; cur.imm=32'hC;
        add(1, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0);
        // v7: load to r8 again
        cur.valid=1; cur.rs=2; cur.rt=8; cur.mr=1; cur.rw=1; cur.alusrc=1; cur.imm=4;
        cur.rs_data=32'h20; cur.rt_data=32'h77; cur.op=3'b010;
        add(0, 1, 32'h20, 4, 3'b010, 0, 32'h77, 8, 1, 1, 0);
        // v8: rt=8 but B is the immediate and no store -> no hazard
        cur.valid=1; cur.rs=3; cur.rt=8; cur.rd=10; cur.regdst=1; cur.alusrc=1; cur.imm=32'hC;
        cur.rs_data=32'h30; cur.rt_data=32'h80; cur.op=3'b001; cur.rw=1;
        add(0, 1, 32'h30, 32'hC, 3'b001, 0, 32'h80, 10, 1, 0, 0);
        // v9: load whose destination is r0
        cur.valid=1; cur.rs=1; cur.rt=0; cur.mr=1; cur.rw=1; cur.alusrc=1; cur.rs_data=5; cur.op=3'b010;
        add(0, 1, 5, 0, 3'b010, 0, 0, 0, 1, 1, 0);
        // v10: reader of r0 after load to r0 -> no hazard
        cur.valid=1; cur.rd=2; cur.regdst=1; cur.rs_data=9; cur.rt_data=32'hA; cur.op=3'b101; cur.rw=1;
        add(0, 1, 9, 32'hA, 3'b101, 0, 32'hA, 2, 1, 0, 0);
        // v11: id_valid=0 forces captured controls low
        cur.valid=0; cur.rs=1; cur.rd=0; cur.regdst=1; cur.rw=1; cur.mr=1; cur.mw=1; cur.rs_data=32'h11; cur.rt_data=32'h22;
        add(0, 0, 32'h11, 32'h22, 3'b000, 0, 32'h22, 0, 0, 0, 0);
        // v12..v15: load then hold for three edges with changing ID
        cur.valid=1; cur.rs=1; cur.rt=2; cur.rd=3; cur.regdst=1; cur.rw=1; cur.rs_data=32'hABC; cur.rt_data=32'hDEF; cur.op=3'b010;
        add(0, 1, 32'hABC, 32'hDEF, 3'b010, 0, 32'hDEF, 3, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cur.stall=1; cur.valid=1; cur.rs=5'(i+6); cur.rt=5'(i+9); cur.rd=5'(i+12); cur.mr=1; cur.mw=1;
            cur.rs_data=32'h1111*(i+1); cur.rt_data=32'h2222*(i+1); cur.op=3'(i+4); cur.unsig=1;
            add(0, 1, 32'hABC, 32'hDEF, 3'b010, 0, 32'hDEF, 3, 1, 0, 0);
        end
        // v16: stall and flush together -> flush wins
        cur.stall=1; cur.flush=1; cur.valid=1; cur.rs=1; cur.rw=1; cur.rs_data=32'h5;
        add(0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0);
        // v17: rs=3 forwarded from MEM over WB
        cur.valid=1; cur.rs=3; cur.rt=4; cur.rd=6; cur.regdst=1; cur.rs_data=32'h1234; cur.rt_data=32'h4321; cur.op=3'b010; cur.rw=1;
        cur.mem_rw=1; cur.mem_rd=3; cur.mem_res=32'hAAAA; cur.wb_rw=1; cur.wb_rd=3; cur.wb_res=32'h5555;
        add(0, 1, 32'hAAAA, 32'h4321, 3'b010, 0, 32'h4321, 6, 1, 0, 0);
        // v18: hold, drop mem_regwrite -> WB value
        cur.stall=1; cur.mem_rw=0; cur.mem_rd=3; cur.mem_res=32'hAAAA; cur.wb_rw=1; cur.wb_rd=3; cur.wb_res=32'h5555;
        add(0, 1, 32'h5555, 32'h4321, 3'b010, 0, 32'h4321, 6, 1, 0, 0);
        // v19: rs=0 with mem_rd=0/wb_rd=0 -> registered data
        cur.valid=1; cur.rs=0; cur.rt=4; cur.rd=6; cur.regdst=1; cur.rs_data=32'h77; cur.rt_data=32'h4321; cur.op=3'b010; cur.rw=1;
        cur.mem_rw=1; cur.mem_rd=0; cur.mem_res=32'hAAAA; cur.wb_rw=1; cur.wb_rd=0; cur.wb_res=32'h5555;
        add(0, 1, 32'h77, 32'h4321, 3'b010, 0, 32'h4321, 6, 1, 0, 0);
        // v20: hold, rt forwarded with MEM beating WB
        cur.stall=1; cur.mem_rw=1; cur.mem_rd=4; cur.mem_res=32'hBEEF; cur.wb_rw=1; cur.wb_rd=4; cur.wb_res=32'h5555;
        add(0, 1, 32'h77, 32'hBEEF, 3'b010, 0, 32'hBEEF, 6, 1, 0, 0);

        // reset state
        apply('0);
        reset = 1'b0;
        #2;
        got = '0;
        chk_outputs("reset", got);
        chk("reset.load_use_stall", {31'b0, load_use_stall}, 32'h0);
        @(negedge clock);
        reset = 1'b1;

        foreach (tbl[i]) begin
            @(negedge clock);
            apply(tbl[i]);
            #1;
            chk($sformatf("v%0d.load_use_stall", i), {31'b0, load_use_stall}, {31'b0, tbl[i].x_lus});
            sb.push_back(tbl[i]);
            @(posedge clock);
            #1;
            if (sb.size() == 0) begin
                chk($sformatf("v%0d.scoreboard_empty", i), 32'h0, 32'h1);
            end else begin
                got = sb.pop_front();
                chk_outputs($sformatf("v%0d", i), got);
            end
        end

        // reset dropped between edges while a valid instruction issues
        @(negedge clock);
        cur = '0;
        cur.valid=1; cur.rs=1; cur.rt=2; cur.rd=3; cur.regdst=1; cur.rw=1; cur.rs_data=32'h55; cur.rt_data=32'h66; cur.op=3'b100;
        apply(cur);
        @(posedge clock);
        #1;
        chk("rst.pre.ex_valid", {31'b0, ex_valid}, 32'h1);
        chk("rst.pre.alu_a", alu_a, 32'h55);
        #2;
        reset = 1'b0;
        #1;
        got = '0;
        chk_outputs("rst.async", got);
        chk("rst.async.load_use_stall", {31'b0, load_use_stall}, 32'h0);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        chk("rst.release.ex_valid", {31'b0, ex_valid}, 32'h1);
        chk("rst.release.alu_a", alu_a, 32'h55);
        chk("rst.release.alu_op", {29'b0, alu_op}, 32'h4);

        // reset during a stall clears the held contents
        @(negedge clock);
        stall = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        chk("rst.stall.ex_valid", {31'b0, ex_valid}, 32'h0);
        chk("rst.stall.ex_regwrite", {31'b0, ex_regwrite}, 32'h0);
        chk("rst.stall.alu_b", alu_b, 32'h0);
        @(negedge clock);
        reset = 1'b1;
        stall = 1'b0;
        @(posedge clock);
        #1;
        chk("rst.stall.reload.ex_rt_data", ex_rt_data, 32'h66);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
